// File: rtl/sar_rx_pkg.sv
// Shared types and constants for the SAR ADC result-capture path.
package sar_rx_pkg;

    // Default raw conversion width; result[RES_W-1] is the first (MSB) decision.
    localparam int RES_W_DEF = 11;

    // Largest averaging exponent: up to 2**3 = 8 conversions per output word.
    localparam int AVG_MAX_LOG2 = 3;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ACC  = 2'd2
    } state_e;

    // Output word width: raw width plus headroom for the largest average.
    function automatic int out_w(input int res_w);
        return res_w + AVG_MAX_LOG2;
    endfunction

endpackage

// File: rtl/sar_result_capture_if.sv
// Show-ahead valid/ready stream carrying normalised conversion words.
interface sar_result_capture_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sar_sync_edge.sv
// Multi-flop synchroniser for the asynchronous conv_done strobe, followed by
// a rising-edge detector that produces a single-cycle capture event.
module sar_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic ev
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the strobe through the synchroniser chain and one history flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history registers.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking assignments here would collapse the chain into one stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign ev = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/sar_result_capture.sv
// Receive end of the SAR ADC: synchronise end-of-conversion, average
// 1/2/4/8 results, normalise to full scale and queue words in a small FIFO.
module sar_result_capture
    import sar_rx_pkg::*;
#(
    parameter int RES_W       = RES_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            conv_done,
    input  logic [RES_W-1:0]                result,
    input  logic                            enable,
    input  logic [1:0]                      avg_sel,
    input  logic                            clear,
    sar_result_capture_if.master            out_if,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [CNT_W-1:0]                word_count
);

    localparam int OUT_W = out_w(RES_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic ev;

    sar_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (conv_done),
        .ev       (ev)
    );

    // ---------------- capture FSM ----------------
    state_e           state_q, state_d;
    logic [1:0]       n_sel_q, n_sel_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             push;
    logic [OUT_W-1:0] push_data;
    logic [OUT_W-1:0] sum;
    logic [1:0]       shamt;

    // Next-state, accumulation and word-push decode.
    // NOTE: every output is given a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        n_sel_d   = n_sel_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = '0;
        sum       = acc_q + OUT_W'(result);
        shamt     = 2'd3 - n_sel_q;

        if (!enable) begin
            // Leaving capture drops any partial average without pushing.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    n_sel_d = avg_sel;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
                ARM: begin
                    if (ev) begin
                        if (n_sel_q == 2'd0) begin
                            push      = 1'b1;
                            push_data = OUT_W'(result) << 3;
                            n_sel_d   = avg_sel;
                        end else begin
                            acc_d   = OUT_W'(result);
                            cnt_d   = 4'd1;
                            state_d = ACC;
                        end
                    end
                end
                ACC: begin
                    if (ev) begin
                        if ((cnt_q + 4'd1) == (4'd1 << n_sel_q)) begin
                            push      = 1'b1;
                            push_data = sum << shamt;
                            acc_d     = '0;
                            cnt_d     = '0;
                            n_sel_d   = avg_sel;
                            state_d   = ARM;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and accumulator registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_sel_q <= 2'd0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_sel_q <= n_sel_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- output FIFO ----------------
    logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] level;
    logic             full, pop, push_ok, dropped;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == PTR_W'(FIFO_DEPTH));
    assign pop     = out_if.out_valid & out_if.out_ready;
    assign push_ok = push & (~full | pop);
    assign dropped = push & full & ~pop;

    // Pointer, storage, overflow and word-counter updates.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Clear first so a coincident drop or accepted push still lands.
        overflow_d   = clear ? 1'b0 : overflow_q;
        word_count_d = clear ? '0 : word_count_q;
        if (dropped) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            word_count_d = word_count_d + 1'b1;
        end
    end

    // Control registers for the FIFO and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    // FIFO storage.
    // NOTE: the data array is not reset; stale entries are never visible
    // because out_data is forced to 0 while the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign out_if.out_valid = (level != '0);
    assign out_if.out_data  = out_if.out_valid ? mem_q[rd_ptr_q[IDX_W-1:0]] : '0;
    assign fifo_level       = level;
    assign overflow         = overflow_q;
    assign word_count       = word_count_q;

endmodule

// File: doc/sar_result_capture.md
Name: sar_result_capture

Overview:
Digital receive end of the SAR ADC conversion interface. It takes the end-of-conversion strobe and the raw result bus from the SAR logic and synchronises the strobe into the system clock. It then optionally averages 1/2/4/8 conversions and presents normalised words on a valid/ready stream through a small FIFO. It sits between the SAR macro and the decimation/readout logic.

Parameters:
RES_W, 11, raw conversion result width (result[RES_W-1] = first decision, MSB)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
SYNC_STAGES, 2, flops in the conv_done synchroniser (>=2)
CNT_W, 16, width of the accepted-word counter

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
conv_done  input  1  end-of-conversion strobe from the SAR logic, asynchronous to clock, level high for >= SYNC_STAGES+2 clock periods
result  input  RES_W  raw conversion code; stable from conv_done rise until SYNC_STAGES+2 clock periods later
enable  input  1  1 = capture conversions; 0 = idle and discard any partial average
avg_sel  input  2  averaging count: 0→1, 1→2, 2→4, 3→8 conversions per output word
clear  input  1  synchronous one-cycle clear of overflow and word_count
out_data  output  RES_W+3  normalised sum: sum << (3-avg_sel)
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head when out_valid & out_ready
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently held
overflow  output  1  sticky: a completed word was dropped because the FIFO was full
word_count  output  CNT_W  completed words written into the FIFO; wraps at 2^CNT_W

Behaviour:
- Reset values: all synchroniser flops 0, FSM IDLE, accumulator 0, sample counter 0, FIFO empty, out_valid 0, out_data 0, fifo_level 0, overflow 0, word_count 0.
- Synchroniser: conv_done passes through SYNC_STAGES flops plus one history flop.
- Capture event ev = sync_out & ~history. This is one cycle per rising edge of conv_done. result is sampled on the ev cycle.
- ev timing: with SYNC_STAGES=2, ev is high in the cycle after the 2nd clock edge that samples conv_done=1.
- FSM:
  - IDLE: accumulator and counter held at 0. enable=1 → ARM, and avg_sel is latched into n_sel.
  - ARM: first ev loads acc=result and cnt=1, then → ACC. If n_sel=0, the word is pushed the same cycle and the FSM stays ARM.
  - ACC: on ev, acc += result and cnt++. When cnt reaches 2^n_sel, push acc+result, clear acc/cnt, re-latch avg_sel, and → ARM.
  - enable=0 in any state → IDLE next edge. A partial accumulation is discarded with no push. Words already in the FIFO are kept.
- avg_sel changes take effect only at the word boundary (IDLE→ARM or after a push). Never mid-word.
- Arithmetic:
  - Accumulator is RES_W+3 bits, unsigned, and cannot overflow (8 × (2^RES_W − 1) fits).
  - Pushed data = final_sum << (3−n_sel), zero-filled LSBs. Every avg setting therefore yields the same full-scale 8×(2^RES_W−1).
- FIFO:
  - Show-ahead: out_data is the head whenever out_valid=1.
  - Pop = out_valid & out_ready.
  - Push when full: accepted only if a pop occurs in the same cycle. Otherwise the word is dropped, overflow is set to 1, and word_count is not incremented.
  - Push when empty: out_valid rises on the next edge. Latency from ev to out_valid is 1 clock (n_sel=0).
  - Simultaneous push and pop with level 0 is impossible (no head). Level is unchanged on simultaneous push and pop.
- word_count increments on every accepted push and wraps to 0 after all-ones.
- clear: overflow←0 and word_count←0. If clear coincides with a dropped push, overflow stays 1 (set wins). If clear coincides with an accepted push, word_count←1.
- ev while in IDLE is ignored. Two ev's cannot occur closer than SYNC_STAGES+2 cycles apart (source requirement); no behaviour is specified otherwise.
- Asserting reset mid-operation immediately empties the FIFO and returns all state to reset values.

Decomposition:
- Package sar_rx_pkg holds:
  - the FSM state enum (IDLE, ARM, ACC)
  - RES_W default
  - the AVG_MAX_LOG2=3 constant
  - the width function for out_data
- Sub-module sar_sync_edge: SYNC_STAGES-flop synchroniser plus rising-edge detector producing ev.
- FIFO stays inline; it is a small register array with read/write pointers plus one extra pointer bit.

Test Plan:
- Reset, enable=1, avg_sel=0, pulse conv_done with result=11'h5A3, out_ready=1 → out_valid high for 1 cycle, out_data=14'h2D18, word_count=1.
- avg_sel=2, four conversions 11'h001, 11'h002, 11'h003, 11'h004 → single word out_data=14'h0014, no word after the first three.
- out_ready=0, avg_sel=0, five conversions with FIFO_DEPTH=4 → fifo_level=4, overflow=1, word_count=4; draining returns the first four results in order.
- avg_sel=3, three conversions, then enable=0, then enable=1 with avg_sel=0 and result=11'h7FF → exactly one word 14'h3FF8; the partial sum is discarded.
- Full FIFO with out_ready=1 in the same cycle as a push → no overflow, level stays 4, word order preserved.
- Assert reset asynchronously mid-ACC with 2 FIFO entries → out_valid, fifo_level, overflow and word_count go to 0 immediately, without waiting for a clock edge.
